setting_sequencer: RTL and testbench

Controller for the manual time-setting path. It turns debounced keypad, `#` and `*` levels into single-cycle key events, steers digits into the hour, minute and second BCD fields in turn, and range-checks the result. A valid time is committed with a one-cycle `completeSetting` pulse; an invalid time raises an error and restarts entry. It sits between the keypad front-end and the clock/alarm registers, replacing ad-hoc per-field enables with one sequenced session.

---
 rtl/setting_pkg.sv | 54 +++++
 rtl/setting_sequencer_if.sv | 36 +++
 rtl/key_event.sv | 47 ++++
 rtl/setting_sequencer.sv | 154 +++++++++++++++
 tb/tb_setting_sequencer.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/setting_pkg.sv
// Shared types for the manual time-setting sequencer: FSM states, BCD fields, status flags.
// Also holds the minute/second limits and small decode helpers used by the top level.
package setting_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HOUR   = 3'd1,
        MIN    = 3'd2,
        SEC    = 3'd3,
        COMMIT = 3'd4,
        ERROR  = 3'd5
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam int MAX_MIN = 59;
    localparam int MAX_SEC = 59;

    typedef struct packed {
        bcd_t hour_ten;
        bcd_t hour_one;
        bcd_t min_ten;
        bcd_t min_one;
        bcd_t sec_ten;
        bcd_t sec_one;
    } fields_t;

    typedef struct packed {
        logic h;
        logic m;
        logic s;
        logic busy;
        logic error;
        logic done;
    } flags_t;

    // Status outputs are registered, so they are loaded from the state being entered.
    function automatic flags_t state_flags(state_t st);
        flags_t f;
        f       = '0;
        f.h     = (st == HOUR);
        f.m     = (st == MIN);
        f.s     = (st == SEC);
        f.busy  = (st != IDLE);
        f.error = (st == ERROR);
        f.done  = (st == COMMIT);
        return f;
    endfunction

    function automatic logic [6:0] bcd_value(bcd_t ten, bcd_t one);
        return 7'(ten) * 7'd10 + 7'(one);
    endfunction

endpackage

// File: rtl/setting_sequencer_if.sv
// Keypad-side inputs and field/status outputs of the time-setting sequencer.
// The slave modport is the sequencer; the master modport is whoever drives the keys.
interface setting_sequencer_if;
    import setting_pkg::*;

    logic       en;
    logic [9:0] keypad;
    logic       sharp;
    logic       star;

    bcd_t       hour_ten_out;
    bcd_t       hour_one_out;
    bcd_t       min_ten_out;
    bcd_t       min_one_out;
    bcd_t       sec_ten_out;
    bcd_t       sec_one_out;
    logic       h;
    logic       m;
    logic       s;
    logic       completeSetting;
    logic       error;
    logic       busy;

    modport master (
        output en, keypad, sharp, star,
        input  hour_ten_out, hour_one_out, min_ten_out, min_one_out, sec_ten_out, sec_one_out,
        input  h, m, s, completeSetting, error, busy
    );

    modport slave (
        input  en, keypad, sharp, star,
        output hour_ten_out, hour_one_out, min_ten_out, min_one_out, sec_ten_out, sec_one_out,
        output h, m, s, completeSetting, error, busy
    );

endinterface

// File: rtl/key_event.sv
// Turns debounced keypad/#/* levels into single-cycle events and a BCD digit.
// Events are combinational on the current sample, so they act at the edge that first sees the level.
module key_event
    import setting_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] keypad,
    input  logic       sharp,
    input  logic       star,
    output logic       digit_ev,
    output bcd_t       digit,
    output logic       sharp_ev,
    output logic       star_ev
);

    logic [9:0] keypad_prev;
    logic       sharp_prev;
    logic       star_prev;
    logic       one_hot;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            keypad_prev <= '0;
            sharp_prev  <= 1'b0;
            star_prev   <= 1'b0;
        end else begin
            keypad_prev <= keypad;
            sharp_prev  <= sharp;
            star_prev   <= star;
        end
    end

    // A new digit needs the pad to have gone fully idle, so chords and rolls never fire.
    assign one_hot  = (|keypad) && ((keypad & (keypad - 10'd1)) == '0);
    assign digit_ev = one_hot && (keypad_prev == '0);
    assign sharp_ev = sharp && !sharp_prev;
    assign star_ev  = star && !star_prev;

    always_comb begin
        digit = '0;
        for (int i = 0; i < 10; i++) begin
            if (keypad[i]) digit = 4'(i);
        end
    end

endmodule

// File: rtl/setting_sequencer.sv
// Sequences one manual time-setting session: HOUR -> MIN -> SEC digit entry, range check, commit or error.
// Inputs act at the sampling edge; all outputs are registered and visible the following cycle.
module setting_sequencer
    import setting_pkg::*;
#(
    parameter int TIMEOUT  = 1000,
    parameter int ERR_HOLD = 4,
    parameter int MAX_HOUR = 23
) (
    input  logic                clk,
    input  logic                rst,
    setting_sequencer_if.slave  bus
);

    localparam int TW = (TIMEOUT  > 2) ? $clog2(TIMEOUT)  : 1;
    localparam int EW = (ERR_HOLD > 1) ? $clog2(ERR_HOLD) : 1;

    state_t       state;
    fields_t      fields;
    flags_t       flags;
    logic [TW-1:0] tcnt;
    logic [EW-1:0] ecnt;

    logic digit_ev;
    bcd_t digit;
    logic sharp_ev;
    logic star_ev;

    key_event u_key_event (
        .clk      (clk),
        .rst      (rst),
        .keypad   (bus.keypad),
        .sharp    (bus.sharp),
        .star     (bus.star),
        .digit_ev (digit_ev),
        .digit    (digit),
        .sharp_ev (sharp_ev),
        .star_ev  (star_ev)
    );

    logic time_ok;
    logic timed_out;

    assign time_ok = (bcd_value(fields.hour_ten, fields.hour_one) <= 7'(MAX_HOUR)) &&
                     (bcd_value(fields.min_ten,  fields.min_one)  <= 7'(MAX_MIN))  &&
                     (bcd_value(fields.sec_ten,  fields.sec_one)  <= 7'(MAX_SEC));

    // The count of idle cycles would reach TIMEOUT-1 on this edge.
    assign timed_out = (tcnt == TW'(TIMEOUT - 2));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            flags  <= '0;
            fields <= '0;
            tcnt   <= '0;
            ecnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.en) begin
                        state  <= HOUR;
                        flags  <= state_flags(HOUR);
                        fields <= '0;
                        tcnt   <= '0;
                    end
                end

                HOUR, MIN, SEC: begin
                    if (star_ev) begin
                        state  <= IDLE;
                        flags  <= state_flags(IDLE);
                        fields <= '0;
                        tcnt   <= '0;
                    end else if (sharp_ev) begin
                        tcnt <= '0;
                        if (state == HOUR) begin
                            state <= MIN;
                            flags <= state_flags(MIN);
                        end else if (state == MIN) begin
                            state <= SEC;
                            flags <= state_flags(SEC);
                        end else if (time_ok) begin
                            state <= COMMIT;
                            flags <= state_flags(COMMIT);
                        end else begin
                            state  <= ERROR;
                            flags  <= state_flags(ERROR);
                            fields <= '0;
                            ecnt   <= '0;
                        end
                    end else if (digit_ev) begin
                        tcnt <= '0;
                        if (state == HOUR) begin
                            fields.hour_ten <= fields.hour_one;
                            fields.hour_one <= digit;
                        end else if (state == MIN) begin
                            fields.min_ten <= fields.min_one;
                            fields.min_one <= digit;
                        end else begin
                            fields.sec_ten <= fields.sec_one;
                            fields.sec_one <= digit;
                        end
                    end else if (timed_out) begin
                        state  <= IDLE;
                        flags  <= state_flags(IDLE);
                        fields <= '0;
                        tcnt   <= '0;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end

                COMMIT: begin
                    state <= IDLE;
                    flags <= state_flags(IDLE);
                end

                ERROR: begin
                    if (ecnt == EW'(ERR_HOLD - 1)) begin
                        state <= HOUR;
                        flags <= state_flags(HOUR);
                        tcnt  <= '0;
                        ecnt  <= '0;
                    end else begin
                        ecnt <= ecnt + EW'(1);
                    end
                end

                default: begin
                    state  <= IDLE;
                    flags  <= '0;
                    fields <= '0;
                    tcnt   <= '0;
                    ecnt   <= '0;
                end
            endcase
        end
    end

    assign bus.hour_ten_out    = fields.hour_ten;
    assign bus.hour_one_out    = fields.hour_one;
    assign bus.min_ten_out     = fields.min_ten;
    assign bus.min_one_out     = fields.min_one;
    assign bus.sec_ten_out     = fields.sec_ten;
    assign bus.sec_one_out     = fields.sec_one;
    assign bus.h               = flags.h;
    assign bus.m               = flags.m;
    assign bus.s               = flags.s;
    assign bus.busy            = flags.busy;
    assign bus.error           = flags.error;
    assign bus.completeSetting = flags.done;

endmodule

// File: tb/tb_setting_sequencer.sv
// Directed bench for setting_sequencer with a per-cycle reference model and literal spot checks.
module tb_setting_sequencer;

    localparam int TMO   = 10;
    localparam int EHOLD = 4;
    localparam int MAXH  = 23;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    setting_sequencer_if bus();

    setting_sequencer #(.TIMEOUT(TMO), .ERR_HOLD(EHOLD), .MAX_HOUR(MAXH)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 hour, 2 min, 3 sec, 4 commit, 5 error; fields as integers.
    int       ph       = 0;
    int       hv       = 0;
    int       mv       = 0;
    int       sv       = 0;
    int       idle_cyc = 0;
    int       err_left = 0;
    bit [9:0] kp_prev  = '0;
    bit       sh_prev  = 1'b0;
    bit       st_prev  = 1'b0;

    function automatic int shift_in(int old, int d);
        return (old % 10) * 10 + d;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph = 0; hv = 0; mv = 0; sv = 0; idle_cyc = 0; err_left = 0;
            kp_prev = '0; sh_prev = 1'b0; st_prev = 1'b0;
        end else begin
            bit dig_e, sh_e, st_e;
            int d;
            d = 0;
            for (int i = 0; i < 10; i++) if (bus.keypad[i]) d = i;
            dig_e = ($countones(bus.keypad) == 1) && (kp_prev == '0);
            sh_e  = bus.sharp && !sh_prev;
            st_e  = bus.star && !st_prev;
            kp_prev = bus.keypad; sh_prev = bus.sharp; st_prev = bus.star;
            case (ph)
                0: if (bus.en) begin ph = 1; hv = 0; mv = 0; sv = 0; idle_cyc = 0; end
                1, 2, 3: begin
                    if (st_e) begin
                        ph = 0; hv = 0; mv = 0; sv = 0;
                    end else if (sh_e) begin
                        idle_cyc = 0;
                        if (ph < 3) ph = ph + 1;
                        else if (hv <= MAXH && mv <= 59 && sv <= 59) ph = 4;
                        else begin ph = 5; hv = 0; mv = 0; sv = 0; err_left = EHOLD; end
                    end else if (dig_e) begin
                        idle_cyc = 0;
                        if (ph == 1) hv = shift_in(hv, d);
                        else if (ph == 2) mv = shift_in(mv, d);
                        else sv = shift_in(sv, d);
                    end else begin
                        idle_cyc = idle_cyc + 1;
                        if (idle_cyc == TMO - 1) begin ph = 0; hv = 0; mv = 0; sv = 0; end
                    end
                end
                4: ph = 0;
                5: begin
                    err_left = err_left - 1;
                    if (err_left == 0) begin ph = 1; idle_cyc = 0; end
                end
                default: ph = 0;
            endcase
        end
    end

    function automatic logic [23:0] fields_now();
        return {bus.hour_ten_out, bus.hour_one_out, bus.min_ten_out,
                bus.min_one_out, bus.sec_ten_out, bus.sec_one_out};
    endfunction

    // Order: fields(24) h m s completeSetting error busy
    always @(negedge clk) begin
        logic [29:0] act, exp;
        act = {fields_now(), bus.h, bus.m, bus.s, bus.completeSetting, bus.error, bus.busy};
        exp = {4'(hv / 10), 4'(hv % 10), 4'(mv / 10), 4'(mv % 10), 4'(sv / 10), 4'(sv % 10),
               ph == 1, ph == 2, ph == 3, ph == 4, ph == 5, ph != 0};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL model_cmp t=%0t got=%h want=%h", $time, act, exp);
        end
    end

    task automatic expect_eq(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_key(int d);
        bus.keypad = 10'(1 << d);
        tick();
        bus.keypad = '0;
        tick();
    endtask

    task automatic press_sharp();
        bus.sharp = 1'b1;
        tick();
        bus.sharp = 1'b0;
        tick();
    endtask

    task automatic press_star();
        bus.star = 1'b1;
        tick();
        bus.star = 1'b0;
        tick();
    endtask

    task automatic start_session();
        bus.en = 1'b1;
        tick();
        bus.en = 1'b0;
    endtask

    task automatic confirm_and_count_error(string name);
        int cnt;
        bus.sharp = 1'b1;
        tick();
        expect_eq({name, "_err_on"}, 32'(bus.error), 32'd1);
        expect_eq({name, "_cleared"}, 32'(fields_now()), 32'h0);
        bus.sharp = 1'b0;
        cnt = 0;
        while (bus.error && cnt < 20) begin
            cnt++;
            tick();
        end
        expect_eq({name, "_err_len"}, 32'(cnt), 32'(EHOLD));
        expect_eq({name, "_h_after"}, 32'(bus.h), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        bus.en = 1'b0; bus.keypad = '0; bus.sharp = 1'b0; bus.star = 1'b0;
        tick(); tick();
        expect_eq("rst_busy", 32'(bus.busy), 32'd0);
        expect_eq("rst_fields", 32'(fields_now()), 32'h0);
        expect_eq("rst_flags", 32'({bus.h, bus.m, bus.s, bus.completeSetting, bus.error}), 32'h0);
        rst_n = 1'b1;
        tick();

        // 12:34:56 commit
        start_session();
        expect_eq("start_h", 32'(bus.h), 32'd1);
        press_key(1); press_key(2); press_sharp();
        expect_eq("to_min", 32'({bus.h, bus.m, bus.s}), 32'b010);
        press_key(3); press_key(4); press_sharp();
        press_key(5); press_key(6);
        bus.sharp = 1'b1;
        tick();
        expect_eq("commit_pulse", 32'(bus.completeSetting), 32'd1);
        expect_eq("commit_fields", 32'(fields_now()), 32'h123456);
        bus.sharp = 1'b0;
        tick();
        expect_eq("commit_end", 32'({bus.completeSetting, bus.busy}), 32'd0);
        tick(); tick();
        expect_eq("held_fields", 32'(fields_now()), 32'h123456);

        // 24:00:00 rejected, then minute 60 rejected
        start_session();
        press_key(2); press_key(4); press_sharp(); press_sharp();
        confirm_and_count_error("hour24");
        press_sharp(); press_key(6); press_key(0); press_sharp();
        confirm_and_count_error("min60");
        press_star();
        expect_eq("star_idle", 32'(bus.busy), 32'd0);

        // digit shifting, chords and held keys
        start_session();
        press_key(9); press_key(1); press_key(7);
        expect_eq("digits_917", 32'(fields_now()), 32'h170000);
        bus.keypad = 10'h003;
        tick(); tick();
        bus.keypad = '0;
        tick();
        expect_eq("chord_ignored", 32'(fields_now()), 32'h170000);
        bus.keypad = 10'(1 << 5);
        repeat (5) tick();
        bus.keypad = '0;
        tick();
        expect_eq("held_one_shift", 32'(fields_now()), 32'h750000);

        // star and sharp together in MIN: cancel wins
        press_sharp(); press_key(3);
        bus.star = 1'b1; bus.sharp = 1'b1;
        tick();
        expect_eq("star_sharp", 32'({fields_now(), bus.busy, bus.completeSetting}), 32'h0);
        bus.star = 1'b0; bus.sharp = 1'b0;
        tick();

        // timeout with no keys in MIN
        start_session();
        bus.sharp = 1'b1;
        tick();
        bus.sharp = 1'b0;
        cnt = 0;
        while (bus.busy && cnt < 30) begin
            tick();
            cnt++;
        end
        expect_eq("timeout_len", 32'(cnt), 32'(TMO - 1));

        // a key at cycle 8 restarts the count
        start_session();
        bus.sharp = 1'b1;
        tick();
        bus.sharp = 1'b0;
        repeat (7) tick();
        expect_eq("tmo_alive7", 32'(bus.m), 32'd1);
        bus.keypad = 10'(1 << 4);
        tick();
        expect_eq("tmo_key8", 32'({bus.m, bus.min_one_out}), 32'h14);
        bus.keypad = '0;
        cnt = 0;
        while (bus.busy && cnt < 30) begin
            tick();
            cnt++;
        end
        expect_eq("tmo_restart", 32'(cnt), 32'(TMO - 1));
        expect_eq("tmo_cleared", 32'(fields_now()), 32'h0);

        // en held through COMMIT restarts after one IDLE cycle
        bus.en = 1'b1;
        tick();
        press_sharp(); press_sharp();
        bus.sharp = 1'b1;
        tick();
        expect_eq("en_commit", 32'(bus.completeSetting), 32'd1);
        bus.sharp = 1'b0;
        tick();
        expect_eq("en_idle", 32'(bus.busy), 32'd0);
        tick();
        expect_eq("en_restart", 32'({bus.h, bus.busy}), 32'b11);
        bus.en = 1'b0;
        press_star();

        // asynchronous reset mid-session
        start_session();
        press_key(5);
        #2 rst_n = 1'b0;
        #1;
        expect_eq("async_rst", 32'({fields_now(), bus.h, bus.busy, bus.completeSetting}), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        expect_eq("post_rst_busy", 32'(bus.busy), 32'd0);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
